// File: rtl/multi_debouncer_pkg.sv
// Shared definitions for the multi-channel debouncer.
//   ch_state_e  : per-channel FSM state encoding (2 bits)
//   width_min1  : $clog2 clamped to a minimum of one bit, for counter widths
package multi_debouncer_pkg;

  typedef enum logic [1:0] {
    StReleased    = 2'd0,
    StPressPend   = 2'd1,
    StPressed     = 2'd2,
    StReleasePend = 2'd3
  } ch_state_e;

  function automatic int unsigned width_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/multi_debouncer_ch.sv
// One debouncer channel: synchronizer chain, 4-state FSM, stability and hold counters,
// registered level and one-cycle strobes.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-low reset
//   tick          in  sample strobe from the shared prescaler
//   btn           in  raw asynchronous button input, 1 = pressed
//   level         out debounced level
//   press         out one-cycle strobe on accepted 0->1
//   release_pulse out one-cycle strobe on accepted 1->0 ("release" is a reserved word)
//   long_press    out one-cycle strobe when the held level reaches LONG_TICKS ticks
module multi_debouncer_ch
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic btn,
  output logic level,
  output logic press,
  output logic release_pulse,
  output logic long_press
);

  localparam int unsigned StabW = width_min1(STABLE_TICKS + 1);
  localparam int unsigned HoldW = width_min1(LONG_TICKS + 1);
  localparam logic [StabW-1:0] StabLast = StabW'(STABLE_TICKS - 1);
  localparam logic [HoldW-1:0] HoldMax  = HoldW'(LONG_TICKS);
  localparam logic [HoldW-1:0] HoldLast = HoldW'(LONG_TICKS - 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   s;

  ch_state_e        state_q, state_d;
  logic [StabW-1:0] stab_q, stab_d;
  logic [HoldW-1:0] hold_q, hold_d;
  logic             level_q, level_d;
  logic             press_q, press_d;
  logic             rel_q, rel_d;
  logic             long_q, long_d;

  assign s = sync_q[SYNC_STAGES-1];

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_q  <= '0;
      state_q <= StReleased;
      stab_q  <= '0;
      hold_q  <= '0;
      level_q <= 1'b0;
      press_q <= 1'b0;
      rel_q   <= 1'b0;
      long_q  <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], btn};
      state_q <= state_d;
      stab_q  <= stab_d;
      hold_q  <= hold_d;
      level_q <= level_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      long_q  <= long_d;
    end
  end

  always_comb begin
    state_d = state_q;
    stab_d  = stab_q;
    hold_d  = hold_q;
    level_d = level_q;
    press_d = 1'b0;
    rel_d   = 1'b0;
    long_d  = 1'b0;
    unique case (state_q)
      StReleased: begin
        if (s) begin
          state_d = StPressPend;
          stab_d  = '0;
        end
      end
      StPressPend: begin
        // A single low sample aborts, tick or not.
        if (!s) begin
          state_d = StReleased;
          stab_d  = '0;
        end else if (tick) begin
          if (stab_q == StabLast) begin
            state_d = StPressed;
            press_d = 1'b1;
            level_d = 1'b1;
            hold_d  = '0;
          end else begin
            stab_d = stab_q + StabW'(1);
          end
        end
      end
      StPressed: begin
        // Leaving for RELEASE_PEND freezes hold; it resumes if the dip is rejected.
        if (!s) begin
          state_d = StReleasePend;
          stab_d  = '0;
        end else if (tick && (hold_q != HoldMax)) begin
          hold_d = hold_q + HoldW'(1);
          long_d = (hold_q == HoldLast);
        end
      end
      StReleasePend: begin
        if (s) begin
          state_d = StPressed;
        end else if (tick) begin
          if (stab_q == StabLast) begin
            state_d = StReleased;
            rel_d   = 1'b1;
            level_d = 1'b0;
          end else begin
            stab_d = stab_q + StabW'(1);
          end
        end
      end
      default: state_d = StReleased;
    endcase
  end

  assign level         = level_q;
  assign press         = press_q;
  assign release_pulse = rel_q;
  assign long_press    = long_q;

endmodule

// File: rtl/multi_debouncer.sv
// N-channel button debouncer: shared sample-tick prescaler plus one independent
// multi_debouncer_ch per channel.
// Ports:
//   clk           in  system clock
//   rst           in  asynchronous active-low reset
//   btn           in  [N_CH] raw button inputs, 1 = pressed
//   level         out [N_CH] debounced levels
//   press         out [N_CH] one-cycle strobes on accepted 0->1
//   release_pulse out [N_CH] one-cycle strobes on accepted 1->0
//   long_press    out [N_CH] one-cycle long-press strobes, at most once per press
module multi_debouncer
  import multi_debouncer_pkg::*;
#(
  parameter int unsigned N_CH         = 4,
  parameter int unsigned SYNC_STAGES  = 2,
  parameter int unsigned TICK_DIV     = 1200,
  parameter int unsigned STABLE_TICKS = 10,
  parameter int unsigned LONG_TICKS   = 1000
) (
  input  logic            clk,
  input  logic            rst,
  input  logic [N_CH-1:0] btn,
  output logic [N_CH-1:0] level,
  output logic [N_CH-1:0] press,
  output logic [N_CH-1:0] release_pulse,
  output logic [N_CH-1:0] long_press
);

  localparam int unsigned CntW = width_min1(TICK_DIV);
  localparam logic [CntW-1:0] CntLast = CntW'(TICK_DIV - 1);

  logic [CntW-1:0] cnt_q, cnt_d;
  logic            tick;

  // With TICK_DIV = 1 the counter sits at 0 and tick is constantly high.
  assign tick  = (cnt_q == CntLast);
  assign cnt_d = tick ? '0 : cnt_q + CntW'(1);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  for (genvar i = 0; i < N_CH; i++) begin : g_ch
    multi_debouncer_ch #(
      .SYNC_STAGES (SYNC_STAGES),
      .STABLE_TICKS(STABLE_TICKS),
      .LONG_TICKS  (LONG_TICKS)
    ) u_ch (
      .clk          (clk),
      .rst          (rst),
      .tick         (tick),
      .btn          (btn[i]),
      .level        (level[i]),
      .press        (press[i]),
      .release_pulse(release_pulse[i]),
      .long_press   (long_press[i])
    );
  end

endmodule

// File: tb/tb_multi_debouncer.sv
// Self-checking bench for multi_debouncer. A TICK_DIV=1 instance is checked every
// cycle against a scoreboard of expected strobe events; a TICK_DIV=8 instance is
// checked with windowed timing.
module tb_multi_debouncer;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] btn, level, press, rel, lng;
  logic [3:0] btn8, level8, press8, rel8, lng8;

  int unsigned cyc = 0;
  int unsigned n_checks = 0;
  int unsigned n_fail = 0;

  typedef struct {
    int unsigned cyc;
    logic [3:0]  press;
    logic [3:0]  rel;
    logic [3:0]  lng;
  } exp_t;

  exp_t sb[$];
  logic [3:0] ep, er, el, level_exp;

  multi_debouncer #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(1), .STABLE_TICKS(4), .LONG_TICKS(16)
  ) dut (
    .clk(clk), .rst(rst), .btn(btn), .level(level), .press(press),
    .release_pulse(rel), .long_press(lng)
  );

  multi_debouncer #(
    .N_CH(4), .SYNC_STAGES(2), .TICK_DIV(8), .STABLE_TICKS(4), .LONG_TICKS(16)
  ) dut8 (
    .clk(clk), .rst(rst), .btn(btn8), .level(level8), .press(press8),
    .release_pulse(rel8), .long_press(lng8)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", tag, got, exp, cyc);
    end
  endtask

  task automatic expect_ev(input int unsigned c, input logic [3:0] p, input logic [3:0] r,
                           input logic [3:0] l);
    exp_t e;
    e.cyc = c; e.press = p; e.rel = r; e.lng = l;
    sb.push_back(e);
  endtask

  task automatic cycles(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // Scoreboard monitor: strobes must match the events due this cycle, else be zero.
  always @(negedge clk) begin
    ep = '0; er = '0; el = '0;
    if (!rst) level_exp = '0;
    for (int i = sb.size() - 1; i >= 0; i--) begin
      if (sb[i].cyc == cyc) begin
        ep = ep | sb[i].press;
        er = er | sb[i].rel;
        el = el | sb[i].lng;
        sb.delete(i);
      end
    end
    level_exp = (level_exp | ep) & ~er;
    check("press", 32'(press), 32'(ep));
    check("release", 32'(rel), 32'(er));
    check("long_press", 32'(lng), 32'(el));
    check("level", 32'(level), 32'(level_exp));
  end

  int unsigned t, seen, start;

  initial begin
    rst = 1'b0; btn = '0; btn8 = '0; level_exp = '0;
    cycles(3);
    check("reset_level", 32'(level), 32'h0);
    check("reset_strobes", 32'({press, rel, lng}), 32'h0);
    rst = 1'b1;
    cycles(5);

    // 1: single press on ch0, then release
    btn[0] = 1'b1; t = cyc + 1;
    expect_ev(t + 6, 4'b0001, 4'b0000, 4'b0000);
    cycles(10);
    btn[0] = 1'b0; t = cyc + 1;
    expect_ev(t + 6, 4'b0000, 4'b0001, 4'b0000);
    cycles(15);

    // 2: bounce on ch1 (3 high / 1 low) must be rejected
    for (int i = 0; i < 10; i++) begin
      btn[1] = 1'b1; cycles(3);
      btn[1] = 1'b0; cycles(1);
    end
    cycles(15);

    // 3: long hold on ch2
    btn[2] = 1'b1; t = cyc + 1;
    expect_ev(t + 6, 4'b0100, 4'b0000, 4'b0000);
    expect_ev(t + 22, 4'b0000, 4'b0000, 4'b0100);
    cycles(30);
    btn[2] = 1'b0; t = cyc + 1;
    expect_ev(t + 6, 4'b0000, 4'b0100, 4'b0000);
    cycles(20);

    // 4: simultaneous press on all channels, short dip on ch3, simultaneous release
    btn = 4'b1111; t = cyc + 1;
    expect_ev(t + 6, 4'b1111, 4'b0000, 4'b0000);
    cycles(8);
    btn[3] = 1'b0; cycles(2);
    btn[3] = 1'b1; cycles(4);
    btn = 4'b0000; t = cyc + 1;
    expect_ev(t + 6, 4'b0000, 4'b1111, 4'b0000);
    cycles(20);

    // 5: reset with ch1 pressed and ch0 pending
    btn[1] = 1'b1; t = cyc + 1;
    expect_ev(t + 6, 4'b0010, 4'b0000, 4'b0000);
    cycles(10);
    check("pre_reset_level", 32'(level), 32'h2);
    btn[0] = 1'b1;
    cycles(3);
    rst = 1'b0; btn = '0;
    #1;
    check("async_reset_level", 32'(level), 32'h0);
    check("async_reset_strobes", 32'({press, rel, lng}), 32'h0);
    cycles(3);
    rst = 1'b1;
    cycles(25);

    // 6: TICK_DIV=8 instance -- a 20-cycle pulse never spans four ticks
    seen = 0;
    btn8[0] = 1'b1; cycles(20);
    btn8[0] = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (press8[0] || level8[0]) seen++;
    end
    check("t6_bounce_rejected", seen, 0);
    cycles(1);

    btn8[0] = 1'b1; start = cyc; seen = 60;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (press8[0]) begin
        seen = cyc - start;
        break;
      end
    end
    check("t6_press_in_window", 32'((seen >= 28) && (seen <= 35)), 32'h1);
    @(negedge clk);
    check("t6_press_one_cycle", 32'(press8[0]), 32'h0);
    check("t6_level", 32'(level8[0]), 32'h1);
    cycles(1);
    btn8[0] = 1'b0;
    cycles(45);
    check("t6_level_released", 32'(level8[0]), 32'h0);

    check("scoreboard_drained", sb.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
